// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encoding for the sequential ALU.
//   - ALU_* operation codes (5-bit ALUOp), including the HI/LO and mul/div ops
//   - FSM state encoding of the iterative mul/div engine
//   - is_muldiv(): selects the ops that go to the multi-cycle engine
// Build option: ALU_DIV_EN builds the divider and enables DIV/DIVU.
package alu_seq_pkg;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_ADDU  = 5'd2;
    localparam logic [4:0] ALU_SUB   = 5'd3;
    localparam logic [4:0] ALU_SUBU  = 5'd4;
    localparam logic [4:0] ALU_AND   = 5'd5;
    localparam logic [4:0] ALU_OR    = 5'd6;
    localparam logic [4:0] ALU_NOR   = 5'd7;
    localparam logic [4:0] ALU_XOR   = 5'd8;
    localparam logic [4:0] ALU_SLT   = 5'd9;
    localparam logic [4:0] ALU_SLTU  = 5'd10;
    localparam logic [4:0] ALU_SLL   = 5'd11;
    localparam logic [4:0] ALU_SLLV  = 5'd12;
    localparam logic [4:0] ALU_SRL   = 5'd13;
    localparam logic [4:0] ALU_SRLV  = 5'd14;
    localparam logic [4:0] ALU_SRA   = 5'd15;
    localparam logic [4:0] ALU_SRAV  = 5'd16;
    localparam logic [4:0] ALU_MULT  = 5'd17;
    localparam logic [4:0] ALU_MULTU = 5'd18;
    localparam logic [4:0] ALU_DIV   = 5'd19;
    localparam logic [4:0] ALU_DIVU  = 5'd20;
    localparam logic [4:0] ALU_MFHI  = 5'd21;
    localparam logic [4:0] ALU_MFLO  = 5'd22;
    localparam logic [4:0] ALU_MTHI  = 5'd23;
    localparam logic [4:0] ALU_MTLO  = 5'd24;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Ops handled by the iterative engine; without the divider DIV/DIVU
    // fall through to the single-cycle path as NOPs.
    function automatic logic is_muldiv(input logic [4:0] op);
        logic r;
        r = (op == ALU_MULT) || (op == ALU_MULTU);
`ifdef ALU_DIV_EN
        r = r || (op == ALU_DIV) || (op == ALU_DIVU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 iterative multiply / divide engine.
//   clk, rstn      clock, async active-low reset
//   start          launch (only honoured in IDLE; caller gates on op type)
//   op             ALUOp of the launched operation
//   a, b           operands (a = multiplicand / dividend)
//   busy           state != IDLE
//   fix            high in the FIX cycle; res_hi/res_lo are valid then
//   res_hi, res_lo sign-corrected HI/LO result
// Build option: ALU_DIV_EN adds the restoring divider.
// acc holds the running high half (product high / partial remainder),
// sr the low half (multiplier shifting out / quotient shifting in).
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fix,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, sr, opb;
    logic               neg_q;

    logic               sgn_op, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        sgn_op = (op == ALU_MULT);
`ifdef ALU_DIV_EN
        if (op == ALU_DIV) sgn_op = 1'b1;
`endif
    end

    assign neg_a = sgn_op & a[WIDTH-1];
    assign neg_b = sgn_op & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    // shift-add: add multiplicand when the outgoing multiplier bit is set,
    // then shift {carry, acc, sr} right by one
    assign msum = {1'b0, acc} + {1'b0, (sr[0] ? opb : '0)};

`ifdef ALU_DIV_EN
    logic           is_div, neg_r, dz;
    logic [WIDTH:0] dsub;
    logic           dge;
    // Partial remainder stays below the divisor, so the trial difference
    // always fits in WIDTH+1 signed bits and its MSB is the borrow.
    assign dsub = {acc, sr[WIDTH-1]} - {1'b0, opb};
    assign dge  = ~dsub[WIDTH];
`endif

    assign prod_fix = neg_q ? -{acc, sr} : {acc, sr};

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (is_div) begin
            // remainder follows the dividend sign; x/0 gives all-ones quotient
            res_hi = neg_r ? -acc : acc;
            res_lo = dz ? '1 : (neg_q ? -sr : sr);
        end
`endif
    end

    assign busy = (state != MD_IDLE);
    assign fix  = (state == MD_FIX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            sr     <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
`ifdef ALU_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    acc    <= '0;
                    sr     <= mag_a;
                    opb    <= mag_b;
                    neg_q  <= neg_a ^ neg_b;
                    cnt    <= '0;
                    state  <= MD_RUN;
`ifdef ALU_DIV_EN
                    is_div <= (op == ALU_DIV) || (op == ALU_DIVU);
                    neg_r  <= neg_a;
                    dz     <= (b == '0);
`endif
                end
                MD_RUN: begin
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        acc <= dge ? dsub[WIDTH-1:0] : {acc[WIDTH-2:0], sr[WIDTH-1]};
                        sr  <= {sr[WIDTH-2:0], dge};
                    end else
`endif
                    begin
                        acc <= msum[WIDTH:1];
                        sr  <= {msum[0], sr[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= MD_FIX;
                end
                MD_FIX:  state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the EX stage.
//   clk, rstn  clock, async active-low reset
//   start      request, sampled only while busy=0
//   ALUOp      operation code (alu_seq_pkg)
//   A, B       operands; A also supplies shift amount and MTHI/MTLO data
//   C, Zero    registered result and C==0
//   busy       iterative mul/div in progress
//   done       one-cycle pulse: C or HI/LO just updated
//   hi, lo     architectural HI/LO registers
// Simple ops and HI/LO moves complete in one registered cycle here;
// MULT/MULTU (and DIV/DIVU with ALU_DIV_EN) run in alu_muldiv_iter.
// WIDTH must be even and >= 8.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] c_nxt, md_hi, md_lo;
    logic             md_op, accept, md_fix;

    assign shamt  = A[SHW-1:0];
    assign md_op  = is_muldiv(ALUOp);
    assign accept = start & ~busy;

    always_comb begin
        c_nxt = A;  // NOP, undefined codes, MTHI/MTLO, DIV/DIVU when not built
        case (ALUOp)
            ALU_ADD, ALU_ADDU: c_nxt = A + B;
            ALU_SUB, ALU_SUBU: c_nxt = A - B;
            ALU_AND:           c_nxt = A & B;
            ALU_OR:            c_nxt = A | B;
            ALU_NOR:           c_nxt = ~(A | B);
            ALU_XOR:           c_nxt = A ^ B;
            ALU_SLT:  begin c_nxt = '0; c_nxt[0] = $signed(A) < $signed(B); end
            ALU_SLTU: begin c_nxt = '0; c_nxt[0] = A < B; end
            ALU_SLL, ALU_SLLV: c_nxt = B << shamt;
            ALU_SRL, ALU_SRLV: c_nxt = B >> shamt;
            ALU_SRA, ALU_SRAV: c_nxt = $signed(B) >>> shamt;
            ALU_MFHI:          c_nxt = hi;
            ALU_MFLO:          c_nxt = lo;
            default:           c_nxt = A;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rstn   (rstn),
        .start  (accept & md_op),
        .op     (ALUOp),
        .a      (A),
        .b      (B),
        .busy   (busy),
        .fix    (md_fix),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // md_fix implies busy, so it never collides with a single-cycle accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            C    <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (md_fix) begin
                hi   <= md_hi;
                lo   <= md_lo;
                done <= 1'b1;
            end else if (accept && !md_op) begin
                C    <= c_nxt;
                done <= 1'b1;
                if (ALUOp == ALU_MTHI) hi <= A;
                if (ALUOp == ALU_MTLO) lo <= A;
            end
        end
    end

    assign Zero = (C == '0);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W  = 32;
    localparam int ML = W + 1;  // start edge to done edge for mul/div

    logic          clk = 1'b0;
    logic          rstn, start;
    logic [4:0]    ALUOp;
    logic [W-1:0]  A, B, C, hi, lo;
    logic          Zero, busy, done;

    int checks = 0, failures = 0, cyc = 0;
    logic [W-1:0] m_c = '0, m_hi = '0, m_lo = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ALUOp(ALUOp), .A(A), .B(B),
        .C(C), .Zero(Zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, c, h, l;
        int          lat;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [4:0] op, input logic [31:0] a, b, c, h, l,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.h = h; v.l = l; v.lat = lat;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for done; lat = edges from start edge s to done edge.
    task automatic wait_done(input int s, output int lat, output int nbusy, output logic bz);
        lat = -1; nbusy = 0; bz = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (done) begin lat = cyc - s; bz = busy; break; end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, b,
                          output int lat, output int nbusy, output logic bz);
        int s;
        @(negedge clk);
        ALUOp = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        wait_done(s, lat, nbusy, bz);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [4:0] op, input logic [31:0] a, b, output int lat);
        int unsigned sh;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p, q, r;
        sh = a[4:0];
        lat = 0;
        case (op)
            ALU_ADD, ALU_ADDU: m_c = a + b;
            ALU_SUB, ALU_SUBU: m_c = a - b;
            ALU_AND:  m_c = a & b;
            ALU_OR:   m_c = a | b;
            ALU_NOR:  m_c = ~(a | b);
            ALU_XOR:  m_c = a ^ b;
            ALU_SLT:  m_c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: m_c = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL, ALU_SLLV: m_c = b << sh;
            ALU_SRL, ALU_SRLV: m_c = b >> sh;
            ALU_SRA, ALU_SRAV: begin sa = $signed(b); sa = sa >>> sh; p = sa; m_c = p[31:0]; end
            ALU_MFHI: m_c = m_hi;
            ALU_MFLO: m_c = m_lo;
            ALU_MTHI: begin m_hi = a; m_c = a; end
            ALU_MTLO: begin m_lo = a; m_c = a; end
            ALU_MULT: begin
                sa = $signed(a); sb = $signed(b); p = sa * sb;
                m_hi = p[63:32]; m_lo = p[31:0]; lat = ML;
            end
            ALU_MULTU: begin
                ua = a; ub = b; p = ua * ub;
                m_hi = p[63:32]; m_lo = p[31:0]; lat = ML;
            end
`ifdef ALU_DIV_EN
            ALU_DIV: begin
                lat = ML;
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin
                    sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            ALU_DIVU: begin
                lat = ML;
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin
                    ua = a; ub = b; q = ua / ub; r = ua % ub;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
`endif
            default: m_c = a;
        endcase
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, nb, s, nd, elat;
        logic bz;
        logic [4:0] op;
        logic [31:0] a, b;

        rstn = 1'b0; start = 1'b0; ALUOp = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c", C, 0);
        chk("rst_zero", Zero, 1);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rstn = 1'b1;

        //   op         A             B             C             HI            LO            lat
        add(ALU_SUB,   32'd5,        32'd5,        32'd0,        32'd0,        32'd0,        0);
        add(ALU_ADD,   32'hFFFFFFFF, 32'd2,        32'd1,        32'd0,        32'd0,        0);
        add(ALU_MULT,  32'hFFFFFFFD, 32'd7,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFEB, ML);
        add(ALU_MFLO,  32'd0,        32'd0,        32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        add(ALU_MULTU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFEB, 32'd1,        32'hFFFFFFFE, ML);
        add(ALU_MFHI,  32'd0,        32'd0,        32'd1,        32'd1,        32'hFFFFFFFE, 0);
        add(ALU_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        32'd1,        32'hFFFFFFFE, 0);
        add(ALU_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        32'hFFFFFFFE, 0);
        add(ALU_SRA,   32'd4,        32'h80000000, 32'hF8000000, 32'd1,        32'hFFFFFFFE, 0);
        add(ALU_SRLV,  32'd4,        32'h80000000, 32'h08000000, 32'd1,        32'hFFFFFFFE, 0);
        add(ALU_SLL,   32'd36,       32'd1,        32'h10,       32'd1,        32'hFFFFFFFE, 0);
        add(ALU_NOR,   32'd0,        32'd0,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0);
        add(ALU_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'd1,        32'hFFFFFFFE, 0);
        add(ALU_MTHI,  32'h1234,     32'd9,        32'h1234,     32'h1234,     32'hFFFFFFFE, 0);
        add(ALU_MTLO,  32'hABCD,     32'd9,        32'hABCD,     32'h1234,     32'hABCD,     0);
        add(5'd31,     32'h55,       32'd9,        32'h55,       32'h1234,     32'hABCD,     0);
        add(ALU_NOP,   32'h77,       32'd9,        32'h77,       32'h1234,     32'hABCD,     0);
`ifdef ALU_DIV_EN
        add(ALU_DIVU,  32'd100,      32'd7,        32'h77,       32'd2,        32'd14,       ML);
        add(ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'h77,       32'hFFFFFFFF, 32'hFFFFFFFD, ML);
        add(ALU_DIV,   32'd5,        32'd0,        32'h77,       32'd5,        32'hFFFFFFFF, ML);
        add(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h77,       32'd0,        32'h80000000, ML);
`else
        add(ALU_DIV,   32'd5,        32'd0,        32'd5,        32'h1234,     32'hABCD,     0);
        add(ALU_DIVU,  32'd100,      32'd7,        32'd100,      32'h1234,     32'hABCD,     0);
`endif

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nb, bz);
            chk($sformatf("t%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("t%0d_nbusy", i), 64'(nb), 64'(tbl[i].lat));
            chk($sformatf("t%0d_busy_at_done", i), bz, 0);
            chk($sformatf("t%0d_c", i), C, tbl[i].c);
            chk($sformatf("t%0d_zero", i), Zero, tbl[i].c == 0);
            chk($sformatf("t%0d_hi", i), hi, tbl[i].h);
            chk($sformatf("t%0d_lo", i), lo, tbl[i].l);
            @(posedge clk); #1;
            chk($sformatf("t%0d_done_pulse", i), done, 0);
            m_c = tbl[i].c; m_hi = tbl[i].h; m_lo = tbl[i].l;
        end

        // start while busy is dropped; MFLO in the done cycle sees new lo
        @(negedge clk);
        ALUOp = ALU_MULTU; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s = cyc;
        repeat (4) @(posedge clk);
        @(negedge clk); ALUOp = ALU_MTHI; A = 32'h999; start = 1'b1;
        @(negedge clk); ALUOp = ALU_MULTU; A = 32'd7; B = 32'd7;
        @(negedge clk); start = 1'b0;
        wait_done(s, lat, nb, bz);
        chk("ign_lat", 64'(lat), 64'(ML));
        chk("ign_hi", hi, 0);
        chk("ign_lo", lo, 15);
        chk("ign_c_kept", C, m_c);
        ALUOp = ALU_MFLO; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_mflo_c", C, 15);
        chk("b2b_mflo_done", done, 1);
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (done) nd++; end
        chk("ign_no_extra_done", 64'(nd), 0);
        chk("ign_hi_final", hi, 0);
        m_hi = 0; m_lo = 15; m_c = 15;

        // reset mid-MULT aborts with HI/LO cleared and no done
        run_op(ALU_MTHI, 32'hDEAD, 32'd0, lat, nb, bz);
        @(negedge clk);
        ALUOp = ALU_MULT; A = 32'd1234; B = 32'd5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_hi_before", hi, 32'hDEAD);
        rstn = 1'b0;
        #2;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk) rstn = 1'b1;
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (done) nd++; end
        chk("abort_no_done", 64'(nd), 0);
        m_c = 0; m_hi = 0; m_lo = 0;

        // randomized ops against the reference model
        for (int k = 0; k < 150; k++) begin
            op = 5'($urandom_range(0, 25));
            if (op == 5'd25) op = 5'd31;
            a = rval();
            b = rval();
            model(op, a, b, elat);
            run_op(op, a, b, lat, nb, bz);
            chk($sformatf("r%0d_op%0d_lat", k, op), 64'(lat), 64'(elat));
            chk($sformatf("r%0d_op%0d_c", k, op), C, m_c);
            chk($sformatf("r%0d_op%0d_hi", k, op), hi, m_hi);
            chk($sformatf("r%0d_op%0d_lo", k, op), lo, m_lo);
            chk($sformatf("r%0d_op%0d_zero", k, op), Zero, m_c == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
